st_order_tracker: RTL and testbench
===================================

Name: st_order_tracker

Overview:
- Sequential successor to the combinational previous-store check.
- Owns the store-buffer writeback bitmap and the commit pointer, and tracks the store-buffer tag of each issue-queue slot.
- Per slot, it latches a sticky "all older stores written back" flag so the scheduler never sees a garbage value after pointer wrap.
- Sits between the scheduler (alloc/dealloc), the store writeback ports and the store-buffer retire logic.

Parameters:
ISSUE_ENTRY, 32, number of issue-queue slots tracked
SB_ENTRY, 16, store-buffer depth (power of 2, >=2)
WB_PORTS, 2, number of store writeback ports per cycle
RETIRE_W, 2, maximum store-buffer entries retired per cycle (<= SB_ENTRY)
CHECK_INCLUSIVE, 1, 1: the slot's own store must also be written back; 0: only strictly older stores

Ports:
clk_i  input  1  clock
reset_n_i  input  1  asynchronous active-low reset
alloc_v_i  input  1  allocate slot this cycle
alloc_idx_i  input  clog2(ISSUE_ENTRY)  slot being allocated
alloc_sb_num_i  input  clog2(SB_ENTRY)  youngest store older than (or equal to) the instruction
alloc_no_st_i  input  1  no older in-flight store; slot is clear immediately
dealloc_v_i  input  1  release slot (issued)
dealloc_idx_i  input  clog2(ISSUE_ENTRY)  slot being released
flush_i  input  1  invalidate all issue slots
wb_v_i  input  WB_PORTS  per-port store writeback valid
wb_sb_num_i  input  WB_PORTS x clog2(SB_ENTRY)  per-port written-back store-buffer entry
retire_cnt_i  input  clog2(RETIRE_W+1)  number of store-buffer entries retired at the head this cycle
st_clear_vector_o  output  ISSUE_ENTRY  slot valid and latched clear
sb_wb_vector_o  output  SB_ENTRY  registered writeback bitmap
sb_commit_pt_o  output  clog2(SB_ENTRY)  registered commit (head) pointer

Behaviour:
- Reset (async, reset_n_i low): all slot valid/clear/tag = 0, wb bitmap = 0, head = 0; all outputs 0.
- WB bitmap update on the clock edge:
  - Bit wb_sb_num_i[p] is set for each p with wb_v_i[p].
  - Duplicate port writes OR together.
  - Retire clears bits head .. head+retire_cnt_i-1 (mod SB_ENTRY), and head <= (head + retire_cnt_i) mod SB_ENTRY.
  - Only entries whose wb bit is already registered set may be retired; the block does not check this.
  - retire_cnt_i > RETIRE_W is illegal.
  - A writeback to an entry being retired in the same cycle is illegal.
- Per-slot check, combinational from registered state:
  - t = (tag - head) mod SB_ENTRY.
  - rot = wb_q rotated right by head.
  - CHECK_INCLUSIVE=1: check = AND of rot[0..t].
  - CHECK_INCLUSIVE=0: check = AND of rot[0..t-1]; t=0 gives check = 1.
- Slot update on the clock edge, highest priority first:
  - flush_i: all valid/clear <= 0. A simultaneous alloc is dropped.
  - alloc_v_i for alloc_idx_i: valid <= 1, tag <= alloc_sb_num_i, clear <= alloc_no_st_i. Alloc wins over dealloc and over check on the same index.
  - dealloc_v_i for dealloc_idx_i: valid <= 0, clear <= 0.
  - Otherwise, for valid slots: clear <= clear | check. Clear is sticky until dealloc/flush/realloc.
- Output: st_clear_vector_o = valid_q & clear_q (registered, no combinational path from inputs).
- Latency:
  - wb_v_i in cycle c: bitmap visible at c+1, clear visible at c+2.
  - Alloc in cycle c with alloc_no_st_i=1: clear visible at c+1.
- Wrap-around: tag arithmetic is modulo SB_ENTRY. Correctness relies on the clear latching at least one cycle before the tag's stores retire. This is guaranteed because retire requires the registered wb bit.
- Alloc tag constraint: alloc_sb_num_i must name an in-flight store unless alloc_no_st_i is set. An already-retired tag is undefined.
- Flush does not touch the wb bitmap or head.
- Reset asserted mid-operation clears everything asynchronously; the first edge after release behaves as from reset.

Test Plan:
- Reset: hold reset_n_i low with random inputs -> all outputs 0. Release -> sb_commit_pt_o=0, st_clear_vector_o=0.
- Basic (SB_ENTRY=8, ISSUE_ENTRY=4, WB_PORTS=2, INCLUSIVE=1):
  - Alloc slot1 tag3 at head0.
  - wb 0,1 in cycle c, wb 2 in c+1 -> bit1 stays 0.
  - wb 3 in c+2 -> st_clear_vector_o[1]=1 at c+4.
- Wrap:
  - Retire to head=6.
  - Alloc slot0 tag1.
  - wb 6,7,0 -> bit0 stays 0.
  - wb 1 -> bit0=1 two cycles later.
  - retire_cnt 2 twice -> head=2, bit0 stays 1.
- Exclusive mode (INCLUSIVE=0): alloc slot2 tag4 at head4 -> bit2=1 two cycles after alloc with no writebacks. Tag5 -> needs wb 4 only.
- Sticky/flush/dealloc:
  - alloc_no_st_i=1 on slot3 -> bit3=1 next cycle.
  - Dealloc slot3 and alloc slot3 same cycle -> slot3 reallocated (alloc wins).
  - flush_i with alloc_v_i -> st_clear_vector_o=0, sb_wb_vector_o unchanged.
- Multi-port: both ports write entry 5 the same cycle -> sb_wb_vector_o[5]=1 only, no side effects. retire_cnt_i=2 from head=7 -> head=1, bits 7 and 0 cleared.

Source files
------------

// File: rtl/st_order_tracker.sv
// Store-order tracker: owns the store-buffer writeback bitmap and commit pointer, and latches a
// sticky per-issue-slot flag once every older store has been written back.
module st_order_tracker #(
  parameter int ISSUE_ENTRY     = 32,
  parameter int SB_ENTRY        = 16,
  parameter int WB_PORTS        = 2,
  parameter int RETIRE_W        = 2,
  parameter int CHECK_INCLUSIVE = 1,
  localparam int IW = $clog2(ISSUE_ENTRY),
  localparam int SW = $clog2(SB_ENTRY),
  localparam int RW = $clog2(RETIRE_W + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   alloc_v_i,
  input  logic [IW-1:0]          alloc_idx_i,
  input  logic [SW-1:0]          alloc_sb_num_i,
  input  logic                   alloc_no_st_i,
  input  logic                   dealloc_v_i,
  input  logic [IW-1:0]          dealloc_idx_i,
  input  logic                   flush_i,
  input  logic [WB_PORTS-1:0]    wb_v_i,
  input  logic [WB_PORTS*SW-1:0] wb_sb_num_i,
  input  logic [RW-1:0]          retire_cnt_i,
  output logic [ISSUE_ENTRY-1:0] st_clear_vector_o,
  output logic [SB_ENTRY-1:0]    sb_wb_vector_o,
  output logic [SW-1:0]          sb_commit_pt_o
);

  logic [ISSUE_ENTRY-1:0] valid_q, valid_d, clear_q, clear_d, check;
  logic [SW-1:0]          tag_q [ISSUE_ENTRY];
  logic [SW-1:0]          tag_d [ISSUE_ENTRY];
  logic [SB_ENTRY-1:0]    wb_q, wb_d, rot;
  logic [2*SB_ENTRY-1:0]  wb_dbl;
  logic [SW-1:0]          head_q, head_d;

  // r is the bitmap rotated so bit 0 is the head; t is the slot's distance from the head.
  function automatic logic older_done(input logic [SB_ENTRY-1:0] r, input logic [SW-1:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < SB_ENTRY; i++) begin
      if ((i < int'(t)) || ((CHECK_INCLUSIVE != 0) && (i == int'(t))))
        ok = ok & r[i];
    end
    return ok;
  endfunction

  assign wb_dbl = {wb_q, wb_q};
  assign rot    = wb_dbl[head_q +: SB_ENTRY];

  always_comb begin
    for (int s = 0; s < ISSUE_ENTRY; s++)
      check[s] = older_done(rot, tag_q[s] - head_q);
  end

  always_comb begin
    wb_d = wb_q;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (RW'(i) < retire_cnt_i)
        wb_d[head_q + SW'(i)] = 1'b0;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_v_i[p])
        wb_d[wb_sb_num_i[p*SW +: SW]] = 1'b1;
    end
    head_d = head_q + SW'(retire_cnt_i);
  end

  // Priority: flush, then alloc, then dealloc, then the sticky check update.
  always_comb begin
    valid_d = valid_q;
    clear_d = clear_q | (valid_q & check);
    tag_d   = tag_q;
    if (flush_i) begin
      valid_d = '0;
      clear_d = '0;
    end else begin
      if (dealloc_v_i) begin
        valid_d[dealloc_idx_i] = 1'b0;
        clear_d[dealloc_idx_i] = 1'b0;
      end
      if (alloc_v_i) begin
        valid_d[alloc_idx_i] = 1'b1;
        clear_d[alloc_idx_i] = alloc_no_st_i;
        tag_d[alloc_idx_i]   = alloc_sb_num_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      clear_q <= '0;
      wb_q    <= '0;
      head_q  <= '0;
      for (int s = 0; s < ISSUE_ENTRY; s++)
        tag_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      clear_q <= clear_d;
      wb_q    <= wb_d;
      head_q  <= head_d;
      for (int s = 0; s < ISSUE_ENTRY; s++)
        tag_q[s] <= tag_d[s];
    end
  end

  assign st_clear_vector_o = valid_q & clear_q;
  assign sb_wb_vector_o    = wb_q;
  assign sb_commit_pt_o    = head_q;

endmodule

// File: tb/tb_st_order_tracker.sv
// Directed bench for st_order_tracker: an inclusive and an exclusive instance share one stimulus.
module tb_st_order_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alloc_v, alloc_no_st, dealloc_v, flush;
  logic [1:0] alloc_idx, dealloc_idx, wb_v, retire_cnt;
  logic [2:0] alloc_sb;
  logic [5:0] wb_num;
  logic [3:0] clr_i, clr_x;
  logic [7:0] wbv_i, wbv_x;
  logic [2:0] head_i, head_x;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  st_order_tracker #(.ISSUE_ENTRY(4), .SB_ENTRY(8), .WB_PORTS(2), .RETIRE_W(2),
                     .CHECK_INCLUSIVE(1)) dut_inc (
    .clk_i(clk), .reset_n_i(reset_n), .alloc_v_i(alloc_v), .alloc_idx_i(alloc_idx),
    .alloc_sb_num_i(alloc_sb), .alloc_no_st_i(alloc_no_st), .dealloc_v_i(dealloc_v),
    .dealloc_idx_i(dealloc_idx), .flush_i(flush), .wb_v_i(wb_v), .wb_sb_num_i(wb_num),
    .retire_cnt_i(retire_cnt), .st_clear_vector_o(clr_i), .sb_wb_vector_o(wbv_i),
    .sb_commit_pt_o(head_i));

  st_order_tracker #(.ISSUE_ENTRY(4), .SB_ENTRY(8), .WB_PORTS(2), .RETIRE_W(2),
                     .CHECK_INCLUSIVE(0)) dut_exc (
    .clk_i(clk), .reset_n_i(reset_n), .alloc_v_i(alloc_v), .alloc_idx_i(alloc_idx),
    .alloc_sb_num_i(alloc_sb), .alloc_no_st_i(alloc_no_st), .dealloc_v_i(dealloc_v),
    .dealloc_idx_i(dealloc_idx), .flush_i(flush), .wb_v_i(wb_v), .wb_sb_num_i(wb_num),
    .retire_cnt_i(retire_cnt), .st_clear_vector_o(clr_x), .sb_wb_vector_o(wbv_x),
    .sb_commit_pt_o(head_x));

  typedef struct {
    logic       av;
    logic [1:0] ai;
    logic [2:0] as;
    logic       ans;
    logic       dv;
    logic [1:0] di;
    logic       fl;
    logic [1:0] wv;
    logic [2:0] w0;
    logic [2:0] w1;
    logic [1:0] rc;
    logic [3:0] ec;
    logic [7:0] ew;
    logic [2:0] eh;
  } vec_t;

  vec_t tbl [0:29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [1:0] ai, input logic [2:0] as, input logic ans,
                       input logic dv, input logic [1:0] di, input logic fl, input logic [1:0] wv,
                       input logic [2:0] w0, input logic [2:0] w1, input logic [1:0] rc);
    alloc_v = av; alloc_idx = ai; alloc_sb = as; alloc_no_st = ans;
    dealloc_v = dv; dealloc_idx = di; flush = fl;
    wb_v = wv; wb_num = {w1, w0}; retire_cnt = rc;
  endtask

  // Apply one cycle of inputs and return just after the capturing edge.
  task automatic step(input logic av, input logic [1:0] ai, input logic [2:0] as, input logic ans,
                      input logic dv, input logic [1:0] di, input logic fl, input logic [1:0] wv,
                      input logic [2:0] w0, input logic [2:0] w1, input logic [1:0] rc);
    @(negedge clk);
    drive(av, ai, as, ans, dv, di, fl, wv, w0, w1, rc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clr_inc"}, 32'(clr_i), 0);
    chk({tag, "_clr_exc"}, 32'(clr_x), 0);
    chk({tag, "_wb"}, 32'(wbv_i), 0);
    chk({tag, "_head"}, 32'(head_i), 0);
  endtask

  initial begin
    //                av ai as ans dv di fl wv     w0 w1 rc  ec       ew     eh
    tbl[0]  = '{1'b1, 2'd1, 3'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h00, 3'd0};
    tbl[1]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 3'd0, 3'd1, 2'd0, 4'b0000, 8'h03, 3'd0};
    tbl[2]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd2, 3'd0, 2'd0, 4'b0000, 8'h07, 3'd0};
    tbl[3]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd3, 3'd0, 2'd0, 4'b0000, 8'h0F, 3'd0};
    tbl[4]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0010, 8'h0F, 3'd0};
    tbl[5]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 3'd4, 3'd5, 2'd2, 4'b0010, 8'h3C, 3'd2};
    tbl[6]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 2'd1, 1'b0, 2'b00, 3'd0, 3'd0, 2'd2, 4'b0000, 8'h30, 3'd4};
    tbl[7]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd2, 4'b0000, 8'h00, 3'd6};
    tbl[8]  = '{1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h00, 3'd6};
    tbl[9]  = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 3'd6, 3'd7, 2'd0, 4'b0000, 8'hC0, 3'd6};
    tbl[10] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd0, 3'd0, 2'd0, 4'b0000, 8'hC1, 3'd6};
    tbl[11] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd1, 3'd0, 2'd0, 4'b0000, 8'hC3, 3'd6};
    tbl[12] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0001, 8'hC3, 3'd6};
    tbl[13] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd2, 4'b0001, 8'h03, 3'd0};
    tbl[14] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd2, 4'b0001, 8'h00, 3'd2};
    tbl[15] = '{1'b1, 2'd3, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b1001, 8'h00, 3'd2};
    tbl[16] = '{1'b1, 2'd3, 3'd2, 1'b1, 1'b1, 2'd3, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b1001, 8'h00, 3'd2};
    tbl[17] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd2, 3'd0, 2'd0, 4'b1001, 8'h04, 3'd2};
    tbl[18] = '{1'b1, 2'd2, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h04, 3'd2};
    tbl[19] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h04, 3'd2};
    tbl[20] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 3'd5, 3'd5, 2'd0, 4'b0000, 8'h24, 3'd2};
    tbl[21] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 3'd3, 3'd4, 2'd0, 4'b0000, 8'h3C, 3'd2};
    tbl[22] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd6, 3'd0, 2'd2, 4'b0000, 8'h70, 3'd4};
    tbl[23] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 3'd7, 3'd0, 2'd2, 4'b0000, 8'hC0, 3'd6};
    tbl[24] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 3'd0, 3'd1, 2'd1, 4'b0000, 8'h83, 3'd7};
    tbl[25] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd2, 4'b0000, 8'h02, 3'd1};
    tbl[26] = '{1'b1, 2'd1, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h02, 3'd1};
    tbl[27] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0010, 8'h02, 3'd1};
    tbl[28] = '{1'b1, 2'd1, 3'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h02, 3'd1};
    tbl[29] = '{1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 3'd0, 3'd0, 2'd0, 4'b0000, 8'h02, 3'd1};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    // Reset held with random inputs toggling.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom_range(0, 2)));
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("rst_release");

    // Basic, wrap, sticky/flush/dealloc and multi-port vectors.
    for (int v = 0; v < 30; v++) begin
      step(tbl[v].av, tbl[v].ai, tbl[v].as, tbl[v].ans, tbl[v].dv, tbl[v].di, tbl[v].fl,
           tbl[v].wv, tbl[v].w0, tbl[v].w1, tbl[v].rc);
      chk($sformatf("v%0d_clear", v), 32'(clr_i), 32'(tbl[v].ec));
      chk($sformatf("v%0d_wb", v), 32'(wbv_i), 32'(tbl[v].ew));
      chk($sformatf("v%0d_head", v), 32'(head_i), 32'(tbl[v].eh));
    end

    // Asynchronous reset in mid-operation, between clock edges.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("async_rst_edge");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("async_rst_release");

    // Exclusive vs inclusive check: move head to 4 first.
    step(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd0, 3'd1, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd2, 3'd3, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0, 2'd2);
    chk("exc_head4", 32'(head_x), 4);
    chk("exc_wb_empty", 32'(wbv_x), 0);
    step(1, 2'd2, 3'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    chk("exc_alloc_t4", 32'(clr_x), 0);
    idle_step();
    chk("exc_t4_clear", 32'(clr_x), 32'h4);
    chk("inc_t4_pending", 32'(clr_i), 0);
    step(1, 2'd2, 3'd5, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    chk("exc_realloc_t5", 32'(clr_x), 0);
    idle_step();
    chk("exc_t5_wait", 32'(clr_x), 0);
    step(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'd4, 3'd0, 2'd0);
    chk("exc_t5_wb4_lat", 32'(clr_x), 0);
    chk("exc_wb4_bit", 32'(wbv_x), 32'h10);
    idle_step();
    chk("exc_t5_clear", 32'(clr_x), 32'h4);
    chk("inc_t5_pending", 32'(clr_i), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
